reg_write_arbiter: RTL

//   Shares one WIDTH-bit register (FDRSE-style D flops, INIT value) between N

---
 rtl/reg_write_arbiter.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/reg_write_arbiter.sv
// Round-robin write arbiter in front of one shared WIDTH-bit register.
// N requesters compete for the register. Each committed write is acknowledged
// with a one-cycle ACK pulse. A writer may keep ownership of the register by
// holding LOCK. A lock timeout forces the register free again.
//
// state     | meaning
// ----------+------------------------------------------------------------
// ST_IDLE   | no owner; next request found from PTR onward wins
// ST_ACKING | write just committed, ACK[OWNER] high; all requests ignored
// ST_HOLD   | owner keeps the lock; only REQ/LOCK of OWNER are honoured
//
// The lock timer counts cycles spent with LOCKED=1. This includes HOLD cycles
// and the ACKING cycles of the owner's re-writes. A re-write does not restart
// the timer. LOCKED stays high for at most LOCK_TIMEOUT cycles. At the edge
// that ends the last allowed cycle, the arbiter returns to IDLE. A re-write
// request from the owner in that cycle is dropped.
module reg_write_arbiter #(
    parameter int               N            = 2,
    parameter int               WIDTH        = 2,
    parameter logic [WIDTH-1:0] INIT         = '0,
    parameter int               LOCK_TIMEOUT = 15,
    localparam int              OW           = (N > 1) ? $clog2(N) : 1
) (
    input  logic                 CLK,
    input  logic                 RESETN,
    input  logic [N-1:0]         REQ,
    input  logic [N-1:0]         LOCK,
    input  logic [N*WIDTH-1:0]   D,
    output logic [N-1:0]         ACK,
    output logic [WIDTH-1:0]     O,
    output logic [OW-1:0]        OWNER,
    output logic                 LOCKED
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACKING = 2'd1,
        ST_HOLD   = 2'd2
    } state_t;

    localparam logic [7:0] TO_LAST = 8'(LOCK_TIMEOUT - 1);

    state_t             state_q, state_d;
    logic [OW-1:0]      ptr_q, ptr_d;
    logic [7:0]         cnt_q, cnt_d;
    logic               lockreq_q, lockreq_d;
    logic [WIDTH-1:0]   o_q, o_d;
    logic [N-1:0]       ack_q, ack_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic               locked_q, locked_d;

    logic [N-1:0]       req_rot;
    int                 win_off;
    int                 win_idx;
    logic [OW-1:0]      win_owner;
    logic [WIDTH-1:0]   win_data;
    logic               win_lock;
    logic [N-1:0]       win_onehot;
    logic               own_req;
    logic               own_lock;
    logic [WIDTH-1:0]   own_data;
    logic [N-1:0]       own_onehot;
    logic [OW-1:0]      owner_inc;
    logic               lock_expired;

    // Pick the round-robin winner and gather the current owner's request lines.
    always_comb begin
        req_rot = N'({REQ, REQ} >> ptr_q);
        win_off = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (req_rot[k]) begin
                win_off = k;
            end
        end
        win_idx = int'(ptr_q) + win_off;
        if (win_idx >= N) begin
            win_idx = win_idx - N;
        end
        win_owner  = OW'(win_idx);
        win_data   = '0;
        win_lock   = 1'b0;
        win_onehot = '0;
        own_req    = 1'b0;
        own_lock   = 1'b0;
        own_data   = '0;
        own_onehot = '0;
        for (int k = 0; k < N; k++) begin
            if (k == win_idx) begin
                win_data      = D[k*WIDTH +: WIDTH];
                win_lock      = LOCK[k];
                win_onehot[k] = 1'b1;
            end
            if (k == int'(owner_q)) begin
                own_data      = D[k*WIDTH +: WIDTH];
                own_req       = REQ[k];
                own_lock      = LOCK[k];
                own_onehot[k] = 1'b1;
            end
        end
        owner_inc    = (int'(owner_q) == N - 1) ? '0 : owner_q + OW'(1);
        lock_expired = locked_q && (cnt_q == TO_LAST);
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d   = state_q;
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        lockreq_d = lockreq_q;
        o_d       = o_q;
        ack_d     = '0;
        owner_d   = owner_q;
        locked_d  = locked_q;
        case (state_q)
            ST_IDLE: begin
                locked_d = 1'b0;
                if (|REQ) begin
                    o_d       = win_data;
                    owner_d   = win_owner;
                    ack_d     = win_onehot;
                    lockreq_d = win_lock;
                    state_d   = ST_ACKING;
                end
            end
            ST_ACKING: begin
                if (lock_expired || !lockreq_q) begin
                    state_d  = ST_IDLE;
                    ptr_d    = owner_inc;
                    locked_d = 1'b0;
                end else begin
                    state_d  = ST_HOLD;
                    locked_d = 1'b1;
                    cnt_d    = locked_q ? cnt_q + 8'd1 : 8'd0;
                end
            end
            ST_HOLD: begin
                if (lock_expired) begin
                    state_d  = ST_IDLE;
                    ptr_d    = owner_inc;
                    locked_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                    if (own_req) begin
                        o_d       = own_data;
                        ack_d     = own_onehot;
                        lockreq_d = own_lock;
                        state_d   = ST_ACKING;
                    end else if (!own_lock) begin
                        state_d  = ST_IDLE;
                        ptr_d    = owner_inc;
                        locked_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d  = ST_IDLE;
                locked_d = 1'b0;
            end
        endcase
    end

    // State and output registers; reset drops any pending ACK and restores INIT.
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q   <= ST_IDLE;
            ptr_q     <= '0;
            cnt_q     <= '0;
            lockreq_q <= 1'b0;
            o_q       <= INIT;
            ack_q     <= '0;
            owner_q   <= '0;
            locked_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            ptr_q     <= ptr_d;
            cnt_q     <= cnt_d;
            lockreq_q <= lockreq_d;
            o_q       <= o_d;
            ack_q     <= ack_d;
            owner_q   <= owner_d;
            locked_q  <= locked_d;
        end
    end

    assign ACK    = ack_q;
    assign O      = o_q;
    assign OWNER  = owner_q;
    assign LOCKED = locked_q;

endmodule
